// File: rtl/meter_time_ctrl.sv
// meter_time_ctrl: parking meter timekeeping with coin add, preset, 1 Hz countdown and sequential BCD conversion
// Ports:
//   clk        system clock (display driver fast clock domain)
//   rst_n      asynchronous active-low reset
//   tick_1hz   one-cycle pulse per second, decrements remaining time
//   add_req    one-cycle coin pulses, highest index wins
//   preset_req one-cycle preset pulses, override adds and ticks
//   digit3..0  BCD thousands..ones of the remaining time
//   blink_req  remaining time below LOW_SECS
//   expired    remaining time is zero
//   busy       BCD conversion in progress
module meter_time_ctrl #(
    parameter int MAX_SECS = 9999,
    parameter int LOW_SECS = 180,
    parameter int ADD0     = 60,
    parameter int ADD1     = 120,
    parameter int ADD2     = 180,
    parameter int ADD3     = 300,
    parameter int PRE0     = 15,
    parameter int PRE1     = 150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [3:0] add_req,
    input  logic [1:0] preset_req,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       blink_req,
    output logic       expired,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state, state_nxt;
    logic [13:0] count, cnt_nxt, add_val, bin;
    logic [14:0] sum;
    logic [15:0] bcd, adj;
    logic [29:0] shifted;
    logic [3:0]  iter;
    logic        dirty;

    always_comb begin
        add_val = add_req[3] ? 14'(ADD3) : add_req[2] ? 14'(ADD2) : add_req[1] ? 14'(ADD1) : 14'(ADD0);
        sum     = {1'b0, count} + {1'b0, add_val};
        cnt_nxt = |preset_req ? (preset_req[1] ? 14'(PRE1) : 14'(PRE0)) :
                  |add_req    ? (sum > 15'(MAX_SECS) ? 14'(MAX_SECS) : sum[13:0]) :
                  (tick_1hz && count != 14'd0) ? count - 14'd1 : count;
    end

    // Shift-add-3: correct every nibble >= 5 before each left shift of {bcd, bin}
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        shifted = {adj, bin} << 1;
    end

    always_comb begin
        state_nxt = (state == IDLE)  ? (dirty ? SHIFT : IDLE) :
                    (state == SHIFT) ? (iter == 4'd13 ? LOAD : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            blink_req <= 1'b1;
            expired   <= 1'b1;
            dirty     <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            {digit3, digit2, digit1, digit0} <= '0;
        end else begin
            count     <= cnt_nxt;
            blink_req <= cnt_nxt < 14'(LOW_SECS);
            expired   <= cnt_nxt == 14'd0;
            // A change coinciding with the snapshot must survive the clear, so set wins
            dirty     <= (cnt_nxt != count) | (dirty & (state != IDLE));
            if (state == IDLE && dirty) begin
                bin  <= count;
                bcd  <= '0;
                iter <= '0;
            end else if (state == SHIFT) begin
                {bcd, bin} <= shifted;
                iter       <= iter + 4'd1;
            end else if (state == LOAD) begin
                {digit3, digit2, digit1, digit0} <= bcd;
            end
        end
    end

    assign busy = state != IDLE;

endmodule

// File: tb/tb_meter_time_ctrl.sv
// tb_meter_time_ctrl: directed self-checking bench for meter_time_ctrl
module tb_meter_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] add_req = '0;
    logic [1:0] preset_req = '0;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       blink_req, expired, busy;
    int         n_chk = 0;
    int         n_fail = 0;

    meter_time_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .add_req(add_req), .preset_req(preset_req),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .blink_req(blink_req), .expired(expired), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the pulse is sampled on the next posedge and we return at the following negedge
    task automatic pulse(input logic [3:0] a, input logic [1:0] p, input logic t);
        add_req = a; preset_req = p; tick_1hz = t;
        @(negedge clk);
        add_req = '0; preset_req = '0; tick_1hz = 1'b0;
    endtask

    function automatic logic [15:0] digs();
        return {digit3, digit2, digit1, digit0};
    endfunction

    initial begin
        cyc(3);
        chk("rst_digits", digs(), 16'h0000);
        chk("rst_expired", 16'(expired), 16'd1);
        chk("rst_blink", 16'(blink_req), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        cyc(5);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_digits", digs(), 16'h0000);

        // Coin add: exact 16-cycle latency
        pulse(4'b0001, 2'b00, 1'b0);
        chk("add60_expired", 16'(expired), 16'd0);
        chk("add60_blink", 16'(blink_req), 16'd1);
        cyc(15);
        chk("add60_old_digits", digs(), 16'h0000);
        chk("add60_busy_load", 16'(busy), 16'd1);
        cyc(1);
        chk("add60_digits", digs(), 16'h0060);
        chk("add60_busy_done", 16'(busy), 16'd0);

        // Preset 150 then countdown to zero
        pulse(4'b0000, 2'b10, 1'b0);
        cyc(16);
        chk("pre150_digits", digs(), 16'h0150);
        for (int v = 149; v >= 0; v--) begin
            pulse(4'b0000, 2'b00, 1'b1);
            chk("cd_expired", 16'(expired), 16'(v == 0));
            cyc(19);
            chk("cd_digits", digs(), to_bcd(v));
        end
        pulse(4'b0000, 2'b00, 1'b1);
        cyc(1);
        chk("tick0_busy", 16'(busy), 16'd0);
        cyc(20);
        chk("tick0_busy_late", 16'(busy), 16'd0);
        chk("tick0_digits", digs(), 16'h0000);
        chk("tick0_expired", 16'(expired), 16'd1);

        // Saturation at MAX_SECS
        repeat (34) pulse(4'b1000, 2'b00, 1'b0);
        cyc(40);
        chk("sat_digits", digs(), 16'h9999);
        chk("sat_blink", 16'(blink_req), 16'd0);
        pulse(4'b1000, 2'b00, 1'b0);
        cyc(1);
        chk("sat_add_busy", 16'(busy), 16'd0);
        cyc(20);
        chk("sat_add_digits", digs(), 16'h9999);
        pulse(4'b0000, 2'b00, 1'b1);
        cyc(16);
        chk("sat_tick_digits", digs(), 16'h9998);
        chk("sat_tick_blink", 16'(blink_req), 16'd0);

        // Priority: 150 + 60 - 10 = 200, then add[3] wins over add[1] and the tick
        pulse(4'b0000, 2'b10, 1'b0);
        pulse(4'b0001, 2'b00, 1'b0);
        repeat (10) pulse(4'b0000, 2'b00, 1'b1);
        cyc(40);
        chk("pri_200", digs(), 16'h0200);
        pulse(4'b1010, 2'b00, 1'b1);
        cyc(40);
        chk("pri_add_over_tick", digs(), 16'h0500);
        chk("pri_500_blink", 16'(blink_req), 16'd0);
        pulse(4'b1000, 2'b01, 1'b1);
        cyc(40);
        chk("pri_preset_over_add", digs(), 16'h0015);
        chk("pri_15_blink", 16'(blink_req), 16'd1);
        chk("pri_15_expired", 16'(expired), 16'd0);

        // Change during conversion: snapshot shown first, then the final count
        pulse(4'b0001, 2'b00, 1'b0);
        cyc(4);
        pulse(4'b0010, 2'b00, 1'b0);
        cyc(10);
        chk("mid_hold_old", digs(), 16'h0015);
        cyc(1);
        chk("mid_snapshot", digs(), 16'h0075);
        chk("mid_busy_gap", 16'(busy), 16'd0);
        cyc(15);
        chk("mid_hold_snap", digs(), 16'h0075);
        cyc(1);
        chk("mid_final", digs(), 16'h0195);
        chk("mid_blink", 16'(blink_req), 16'd0);

        // Asynchronous reset in the middle of SHIFT
        pulse(4'b0001, 2'b00, 1'b0);
        cyc(5);
        chk("pre_rst_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_digits", digs(), 16'h0000);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_blink", 16'(blink_req), 16'd1);
        chk("arst_expired", 16'(expired), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        chk("post_rst_busy", 16'(busy), 16'd0);
        chk("post_rst_digits", digs(), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/meter_time_ctrl.md
Name: meter_time_ctrl

Overview:
- Timekeeping controller for the parking meter. Holds remaining time in seconds and applies coin-add and preset requests.
- Decrements the time once per 1 Hz tick enable.
- Converts the count to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives the digit3..digit0 and blink-request inputs of the 7-segment display driver. Sits between the debounced button/coin logic and the display.

Parameters:
- MAX_SECS, 9999, saturation ceiling for remaining time.
- LOW_SECS, 180, blink_req asserts while remaining time is below this value.
- ADD0, 60, seconds added by add_req[0].
- ADD1, 120, seconds added by add_req[1].
- ADD2, 180, seconds added by add_req[2].
- ADD3, 300, seconds added by add_req[3].
- PRE0, 15, value loaded by preset_req[0].
- PRE1, 150, value loaded by preset_req[1].

Ports:
- clk  in  1  system clock, same domain as the display driver fast clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  single-cycle enable pulse, once per second.
- add_req  in  4  single-cycle add pulses (coins).
- preset_req  in  2  single-cycle preset pulses.
- digit3  out  4  BCD thousands.
- digit2  out  4  BCD hundreds.
- digit1  out  4  BCD tens.
- digit0  out  4  BCD ones.
- blink_req  out  1  display blink request; drives the display driver blink input.
- expired  out  1  remaining time is zero.
- busy  out  1  BCD conversion in progress.

Behaviour:
- Reset (async assert, sync release):
  - count=0, digits all 0.
  - blink_req=1, expired=1, busy=0.
  - Conversion FSM in IDLE, dirty=0.
- Count register is 14 bits. Per cycle, highest priority wins; only one action applies:
  1. Any preset_req bit: count<=PRE1 if preset_req[1], else PRE0. All add and tick inputs that cycle are ignored.
  2. Any add_req bit: the highest set index wins. count<=min(count+ADDn, MAX_SECS). The sum is computed 15-bit before saturation. A coincident tick is dropped.
  3. tick_1hz: count<=count-1 if count>0. At count 0 it holds at 0; there is no wrap.
- blink_req and expired are registered from the count's next value, so they update in the same cycle as count.
  - blink_req=(count<LOW_SECS).
  - expired=(count==0).
- dirty flag:
  - Set on any cycle where count changes value.
  - Cleared when the FSM leaves IDLE.
  - A pulse that leaves count unchanged does not set dirty. Examples: tick at 0, or add while already at MAX_SECS.
- Conversion FSM:
  - IDLE: if dirty, snapshot count into the shift register, clear the 16-bit BCD accumulator, clear dirty, go to SHIFT. busy=1 from this edge.
  - SHIFT: 14 iterations, one per cycle. Each iteration first adds 3 to every BCD nibble that is >=5, then left-shifts {bcd, bin} by one. After iteration 14, go to LOAD.
  - LOAD: digit3..0<=bcd nibbles in one cycle; busy=0; go to IDLE.
- Latency:
  - A count update at edge N gives new digits visible after edge N+16.
  - IDLE to SHIFT is 1 cycle, SHIFT is 14 cycles, LOAD is 1 cycle.
  - The digits hold their previous value throughout the conversion; no intermediate value is ever output.
- A count change during SHIFT or LOAD sets dirty. A fresh conversion then starts immediately after returning to IDLE, so the final digits always equal the final count. The in-flight snapshot is not aborted.
- Reset mid-conversion: all state returns to reset values immediately, and the partial BCD result is discarded.
- Digits are always valid BCD (0-9) because count<=9999.

Test Plan:
- Reset, release, no inputs: digits=0000, expired=1, blink_req=1, busy stays 0 (no dirty).
- add_req=4'b0001, wait 20 cycles: count=60, digits 0060 appear exactly 16 cycles after the pulse edge, blink_req=1, expired=0.
- preset_req[1], then 150 ticks spaced >=20 cycles apart: digits step 0150->0149->...->0000. expired rises on the tick reaching 0; a further tick leaves 0000 and busy stays 0.
- add_req[3] repeated 34 times: count saturates at 9999, digits 9999. A further add causes no conversion. Then tick once: digits 9998, blink_req=0.
- Same cycle add_req=4'b1010, tick_1hz=1, count=200: count=500, tick dropped. Same cycle preset_req[0] with add_req[3]: count=15.
- Add pulse issued 5 cycles into a conversion: digits first show the snapshot value, then the final count 16 cycles after the first LOAD. Separately, assert rst_n=0 mid-SHIFT: outputs return to reset values immediately.
